// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;

  // Byte-lane mask of an access before it is shifted to its address offset.
  // Encoding 2'b11 falls into the word case.
  function automatic logic [3:0] width_mask(input logic [1:0] width);
    case (width)
      WIDTH_HALF: return 4'b0011;
      WIDTH_BYTE: return 4'b0001;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store data shift, byte enables, and load extraction
// with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_width,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword_lo,
  input  logic [23:0] i_rword_hi,
  output logic [31:0] o_wdata_lo,
  output logic [31:0] o_wdata_hi,
  output logic [3:0]  o_be_lo,
  output logic [3:0]  o_be_hi,
  output logic        o_split,
  output logic [31:0] o_rdata
);

  logic [63:0] w_wshift;
  logic [7:0]  w_be;
  logic [31:0] w_rshift;

  // Shift store data and lane mask across a two-word window; the upper word
  // is only used when the access spills past the word boundary.
  always_comb begin
    w_wshift   = {32'b0, i_wdata} << {i_offset, 3'b000};
    w_be       = {4'b0000, width_mask(i_width)} << i_offset;
    o_wdata_lo = w_wshift[31:0];
    o_wdata_hi = w_wshift[63:32];
    o_be_lo    = w_be[3:0];
    o_be_hi    = w_be[7:4];
    o_split    = |w_be[7:4];
  end

  // Pull the addressed bytes down to bit 0 (little-endian), then extend.
  always_comb begin
    case (i_offset)
      2'd0:    w_rshift = i_rword_lo;
      2'd1:    w_rshift = {i_rword_hi[7:0],  i_rword_lo[31:8]};
      2'd2:    w_rshift = {i_rword_hi[15:0], i_rword_lo[31:16]};
      default: w_rshift = {i_rword_hi[23:0], i_rword_lo[31:24]};
    endcase
    case (i_width)
      WIDTH_HALF: o_rdata = {{16{~i_unsigned & w_rshift[15]}}, w_rshift[15:0]};
      WIDTH_BYTE: o_rdata = {{24{~i_unsigned & w_rshift[7]}},  w_rshift[7:0]};
      default:    o_rdata = w_rshift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a single CPU memory request into one or two
// word-aligned bus transfers, stalling the pipeline until it completes.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  DataWidth,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  lsu_state_t  w_state_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic [31:0] r_read_data;
  logic [1:0]  r_width;
  logic        r_unsigned;
  logic        r_we;

  logic        w_req;
  logic        w_split;
  logic        w_xfer;
  logic        w_last;
  logic [31:0] w_wdata_lo;
  logic [31:0] w_wdata_hi;
  logic [3:0]  w_be_lo;
  logic [3:0]  w_be_hi;
  logic [31:0] w_rword_lo;
  logic [31:0] w_load_data;

  assign w_req    = MemRead | MemWrite;
  assign w_xfer   = mem_req & mem_ready;
  // Final transfer of the access: aligned FIRST, or SECOND of a split.
  assign w_last   = w_xfer & ((r_state == SECOND) | ~w_split);
  // On an aligned load the low word comes straight off the bus.
  assign w_rword_lo = (r_state == FIRST) ? mem_rdata : r_word0;
  assign ReadData = r_read_data;

  lsu_align u_align (
    .i_offset   (r_addr[1:0]),
    .i_width    (r_width),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rword_lo (w_rword_lo),
    .i_rword_hi (mem_rdata[23:0]),
    .o_wdata_lo (w_wdata_lo),
    .o_wdata_hi (w_wdata_hi),
    .o_be_lo    (w_be_lo),
    .o_be_hi    (w_be_hi),
    .o_split    (w_split),
    .o_rdata    (w_load_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, stall and bus outputs; bus is driven only from latched state
  // so it stays stable while mem_ready is low.
  always_comb begin
    w_state_next = r_state;
    Stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'b0;
    mem_wdata    = 32'b0;
    mem_be       = 4'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          Stall        = 1'b1;
          w_state_next = FIRST;
        end
      end
      FIRST: begin
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_wdata = w_wdata_lo;
        mem_be    = w_be_lo;
        if (mem_ready) begin
          w_state_next = w_split ? SECOND : DONE;
        end
      end
      SECOND: begin
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        // 30-bit word address wraps naturally at the top of memory.
        mem_addr  = {r_addr[31:2] + 30'd1, 2'b00};
        mem_wdata = w_wdata_hi;
        mem_be    = w_be_hi;
        if (mem_ready) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Request latch, first-word capture and load result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= 32'b0;
      r_wdata     <= 32'b0;
      r_width     <= WIDTH_WORD;
      r_unsigned  <= 1'b0;
      r_we        <= 1'b0;
      r_word0     <= 32'b0;
      r_read_data <= 32'b0;
    end else begin
      if ((r_state == IDLE) && w_req) begin
        r_addr     <= Addr;
        r_wdata    <= WriteData;
        r_width    <= DataWidth;
        r_unsigned <= Unsigned;
        r_we       <= MemWrite;  // store wins when both are requested
      end
      if ((r_state == FIRST) && w_xfer) begin
        r_word0 <= mem_rdata;
      end
      if (w_last && !r_we) begin
        r_read_data <= w_load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a simple bus responder.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  DataWidth;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .DataWidth (DataWidth),
    .Unsigned  (Unsigned),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rlo;
    logic [31:0] rhi;
    int          waits;
    int          exp_stall;
    int          exp_beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string n, input string what, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%h expected=%h", n, what, got, exp);
    end
  endtask

  // Drive one request and act as the memory until the unit reaches DONE.
  // Entered and left just after a rising edge.
  task automatic run_txn(input vec_t v);
    logic [31:0] ga [2];
    logic [3:0]  gb [2];
    logic [31:0] gw [2];
    logic        gwe [2];
    int beat = 0;
    int wait_cnt = 0;
    int stalls = 0;
    bit done = 0;
    bit stable = 1;
    bit xfer = 0;
    for (int i = 0; i < 2; i++) begin
      ga[i] = 'x; gb[i] = 'x; gw[i] = 'x; gwe[i] = 1'bx;
    end
    MemRead   = v.rd;
    MemWrite  = v.wr;
    DataWidth = v.width;
    Unsigned  = v.uns;
    Addr      = v.addr;
    WriteData = v.wdata;
    mem_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!Stall) begin
        done = 1;
        chk(v.name, "req_in_done", {31'b0, mem_req}, 32'd0);
        chk(v.name, "read_data", ReadData, v.exp_rd);
      end else begin
        stalls++;
        if (mem_req) begin
          if (wait_cnt == 0) begin
            if (beat < 2) begin
              ga[beat] = mem_addr; gb[beat] = mem_be; gw[beat] = mem_wdata; gwe[beat] = mem_we;
            end
          end else if (beat < 2) begin
            if (mem_addr !== ga[beat] || mem_be !== gb[beat] || mem_wdata !== gw[beat] ||
                mem_we !== gwe[beat]) stable = 0;
          end
          if (wait_cnt < v.waits) begin
            mem_ready = 1'b0;
            wait_cnt++;
          end else begin
            mem_ready = 1'b1;
            mem_rdata = (beat == 0) ? v.rlo : v.rhi;
            xfer = 1;
          end
        end
      end
      @(posedge clk);
      #1;
      if (xfer) begin
        beat++;
        wait_cnt = 0;
        xfer = 0;
      end
      mem_ready = 1'b0;
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    chk(v.name, "completed", {31'b0, done}, 32'd1);
    chk(v.name, "stall_cycles", stalls, v.exp_stall);
    chk(v.name, "beats", beat, v.exp_beats);
    chk(v.name, "bus_stable", {31'b0, stable}, 32'd1);
    chk(v.name, "addr0", ga[0], v.a0);
    chk(v.name, "be0", {28'b0, gb[0]}, {28'b0, v.be0});
    chk(v.name, "we0", {31'b0, gwe[0]}, {31'b0, v.wr});
    if (v.wr) chk(v.name, "wdata0", gw[0], v.wd0);
    if (v.exp_beats > 1) begin
      chk(v.name, "addr1", ga[1], v.a1);
      chk(v.name, "be1", {28'b0, gb[1]}, {28'b0, v.be1});
      chk(v.name, "we1", {31'b0, gwe[1]}, {31'b0, v.wr});
      if (v.wr) chk(v.name, "wdata1", gw[1], v.wd1);
    end
  endtask

  initial begin
    // name, rd, wr, width, uns, addr, wdata, rlo, rhi, waits, stall, beats,
    // a0, be0, wd0, a1, be1, wd1, expected ReadData
    vecs[0]  = '{"lw_aligned", 1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0,
                 2, 1, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{"lb_signed", 1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h80123456, 32'h0, 0,
                 2, 1, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{"lb_unsigned", 1'b1, 1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'h80123456, 32'h0, 0,
                 2, 1, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000080};
    vecs[3]  = '{"sw_split", 1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'h11223344, 32'h0, 32'h0, 0,
                 3, 2, 32'h100, 4'hC, 32'h33440000, 32'h104, 4'h3, 32'h00001122, 32'h00000080};
    vecs[4]  = '{"lh_split_wait", 1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 32'hAB000000,
                 32'h000000CD, 2, 7, 2, 32'h100, 4'h8, 32'h0, 32'h104, 4'h1, 32'h0, 32'hFFFFCDAB};
    vecs[5]  = '{"lhu_off2", 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h87654321, 32'h0, 0,
                 2, 1, 32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00008765};
    vecs[6]  = '{"lh_off2", 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h87654321, 32'h0, 0,
                 2, 1, 32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8765};
    vecs[7]  = '{"sb_off1", 1'b0, 1'b1, 2'b10, 1'b0, 32'h101, 32'hAABBCCDD, 32'h0, 32'h0, 0,
                 2, 1, 32'h100, 4'h2, 32'hBBCCDD00, 32'h0, 4'h0, 32'h0, 32'hFFFF8765};
    vecs[8]  = '{"lw_wrap", 1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFFFFFD, 32'h0, 32'h11223344,
                 32'h55667788, 0, 3, 2, 32'hFFFFFFFC, 4'hE, 32'h0, 32'h0, 4'h1, 32'h0,
                 32'h88112233};
    vecs[9]  = '{"lw_width11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 32'h0BADF00D, 32'h0, 0,
                 2, 1, 32'h200, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0BADF00D};
    vecs[10] = '{"sw_b2b", 1'b0, 1'b1, 2'b00, 1'b0, 32'h200, 32'hCAFEBABE, 32'h0, 32'h0, 0,
                 2, 1, 32'h200, 4'hF, 32'hCAFEBABE, 32'h0, 4'h0, 32'h0, 32'h0BADF00D};
    vecs[11] = '{"lw_b2b", 1'b1, 1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 32'h12345678, 32'h0, 0,
                 2, 1, 32'h200, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h12345678};
    vecs[12] = '{"rdwr_store", 1'b1, 1'b1, 2'b01, 1'b0, 32'h201, 32'h0000BEEF, 32'hFFFFFFFF,
                 32'h0, 0, 2, 1, 32'h200, 4'h6, 32'h00BEEF00, 32'h0, 4'h0, 32'h0, 32'h12345678};
    vecs[13] = '{"lw_off2_wait", 1'b1, 1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 32'h44332211,
                 32'h88776655, 1, 5, 2, 32'h300, 4'hC, 32'h0, 32'h304, 4'h3, 32'h0,
                 32'h66554433};
    vecs[14] = '{"lh_off1", 1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0012F400, 32'h0, 0,
                 2, 1, 32'h100, 4'h6, 32'h0, 32'h0, 4'h0, 32'h0, 32'h000012F4};
    vecs[15] = '{"lw_after_rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h01020304, 32'h0, 0,
                 2, 1, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h01020304};

    rst       = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    DataWidth = 2'b00;
    Unsigned  = 1'b0;
    Addr      = 32'h0;
    WriteData = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    #2;
    chk("reset", "stall", {31'b0, Stall}, 32'd0);
    chk("reset", "mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset", "mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset", "mem_be", {28'b0, mem_be}, 32'd0);
    chk("reset", "mem_addr", mem_addr, 32'd0);
    chk("reset", "mem_wdata", mem_wdata, 32'd0);
    chk("reset", "read_data", ReadData, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Consecutive calls put each new request in the cycle right after DONE.
    for (int i = 0; i < 15; i++) run_txn(vecs[i]);

    // Reset while the second half of a split store is pending.
    MemWrite  = 1'b1;
    DataWidth = 2'b00;
    Addr      = 32'h102;
    WriteData = 32'h55AA55AA;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    MemWrite  = 1'b0;
    @(negedge clk);
    chk("rst_mid", "req_in_second", {31'b0, mem_req}, 32'd1);
    chk("rst_mid", "addr_in_second", mem_addr, 32'h104);
    rst = 1'b1;
    #1;
    chk("rst_mid", "mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid", "stall", {31'b0, Stall}, 32'd0);
    chk("rst_mid", "read_data", ReadData, 32'd0);
    chk("rst_mid", "mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mid", "mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // A fresh aligned load must start from IDLE with the normal latency.
    run_txn(vecs[15]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port MemRead  in  1  load request from control unit.
REQ-004 SHALL have port MemWrite  in  1  store request from control unit.
REQ-005 SHALL have port DataWidth  in  2  00 word, 01 half, 10 byte, 11 treated as word.
REQ-006 SHALL have port Unsigned  in  1  funct3[2]; zero-extend loads when 1, sign-extend when 0.
REQ-007 SHALL have port Addr  in  32  byte address from ALU.
REQ-008 SHALL have port WriteData  in  32  store data, right-justified.
REQ-009 SHALL have port ReadData  out  32  extended load result.
REQ-010 SHALL have port Stall  out  1  freezes PC/pipeline while high.
REQ-011 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32 (bits [1:0]=00), mem_wdata out 32, mem_be out 4, mem_ready in 1, mem_rdata in 32.

Function
REQ-012 SHALL implement FSM states IDLE, FIRST, SECOND, DONE.
REQ-013 IDLE: on MemRead|MemWrite SHALL latch Addr, WriteData, DataWidth, Unsigned, direction; assert Stall combinationally that cycle; go FIRST.
REQ-014 MemRead and MemWrite both high SHALL be executed as a store only.
REQ-015 Access SHALL be split when it crosses a word boundary: half at offset 3, word at offsets 1-3.
REQ-016 FIRST SHALL drive mem_req=1, word address Addr[31:2], lane-shifted data and byte enables for the low part; SHALL hold all bus outputs stable until mem_req&mem_ready.
REQ-017 On FIRST transfer SHALL go SECOND if split, else DONE; SECOND SHALL access word address+1 with the remaining lanes, then go DONE.
REQ-018 Word address+1 SHALL wrap from 0x3FFFFFFF to 0.
REQ-019 Loads SHALL capture mem_rdata at each transfer and assemble bytes in address order (little-endian).
REQ-020 DONE SHALL deassert Stall and present the final ReadData; the next state SHALL be IDLE.
REQ-021 Stall SHALL be high in IDLE (when request seen), FIRST, and SECOND; low otherwise.
REQ-022 mem_req SHALL be low in IDLE and DONE.
REQ-023 Latency with mem_ready held high SHALL be 2 stall cycles aligned, 3 stall cycles split; each low mem_ready cycle adds one.
REQ-024 ReadData SHALL hold its value until the next load reaches DONE; stores SHALL not alter it.
REQ-025 Byte loads SHALL extend bit 7, half loads bit 15, per Unsigned.
REQ-026 A request present in the cycle after DONE SHALL be accepted normally from IDLE.

Reset
REQ-027 rst SHALL asynchronously force IDLE, Stall=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadData=0.
REQ-028 Reset mid-transaction SHALL abort it; a split store may leave only its first part written.

Structure
REQ-029 Package lsu_pkg SHALL hold the state enum and DataWidth encodings (WIDTH_WORD, WIDTH_HALF, WIDTH_BYTE).
REQ-030 Combinational lane shift, byte-enable generation and sign/zero extension SHALL live in sub-module lsu_align.

Verification
REQ-031 Aligned LW, Addr=0x100, mem_rdata=0xDEADBEEF, ready high -> Stall 2 cycles, ReadData=0xDEADBEEF.
REQ-032 LB Addr=0x103, rdata=0x80xxxxxx, Unsigned=0 -> 0xFFFFFF80; Unsigned=1 -> 0x00000080.
REQ-033 SW Addr=0x102, WriteData=0x11223344 -> writes 0x100 be=1100 data 0x33440000, then 0x104 be=0011 data 0x00001122; Stall 3 cycles.
REQ-034 LH Addr=0x103, ready low 2 cycles per transfer -> bus outputs stable while waiting, Stall 7 cycles, result correct.
REQ-035 rst asserted in SECOND -> mem_req low immediately, FSM IDLE, ReadData=0, Stall=0.
REQ-036 Back-to-back SW then LW, and MemRead&MemWrite together -> second accepted cycle after DONE; combined request performs store only.
